simple_acc_ctrl: RTL and testbench

//   Self-contained accumulate controller with a small FSM and datapath.
//   On start_i it sums the integers 1..N_COUNT into a 32-bit accumulator, one term per clock.
//   It then raises done_o and holds the result on acc_o.

---
 rtl/simple_acc_ctrl.sv | 81 ++++++++
 tb/tb_simple_acc_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_acc_ctrl.sv
// Accumulate controller: on start, sums 1..N_COUNT into a modular accumulator, one term per clock,
// then raises done and holds the result until start is released.
module simple_acc_ctrl #(
    parameter int unsigned N_COUNT = 10,
    parameter int unsigned ACC_W   = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    output logic             done_o,
    output logic [ACC_W-1:0] acc_o
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam logic [15:0] CntLast = 16'(N_COUNT);

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             done_q, done_d;
    logic [ACC_W-1:0] cnt_ext;

    // Term is reduced mod 2^ACC_W before the add; the sum wraps the same either way.
    assign cnt_ext = ACC_W'(cnt_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    cnt_d   = 16'd1;
                    acc_d   = '0;
                end
            end
            StRun: begin
                acc_d = acc_q + cnt_ext;
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                // A held start must not retrigger; wait for it to drop.
                if (start_i) begin
                    done_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign done_o = done_q;
    assign acc_o  = acc_q;

endmodule

// File: tb/tb_simple_acc_ctrl.sv
// Directed bench for simple_acc_ctrl: default instance plus N_COUNT=1, 8-bit wrap and max-count.
module tb_simple_acc_ctrl;

    logic        clk;
    logic        rstn;
    logic        start, start1, start8, startm;
    logic        done, done1, done8, donem;
    logic [31:0] acc, acc1, accm;
    logic [7:0]  acc8;

    int tests_run;
    int tests_failed;

    simple_acc_ctrl dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .start_i(start),
        .done_o (done),
        .acc_o  (acc)
    );

    simple_acc_ctrl #(.N_COUNT(1), .ACC_W(32)) dut_n1 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .start_i(start1),
        .done_o (done1),
        .acc_o  (acc1)
    );

    simple_acc_ctrl #(.N_COUNT(30), .ACC_W(8)) dut_w8 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .start_i(start8),
        .done_o (done8),
        .acc_o  (acc8)
    );

    simple_acc_ctrl #(.N_COUNT(65535), .ACC_W(32)) dut_max (
        .clk_i  (clk),
        .rstn_i (rstn),
        .start_i(startm),
        .done_o (donem),
        .acc_o  (accm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        start8 = 1'b0;
        startm = 1'b0;
        #3;
        tests_run++;
        if (acc !== 32'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: acc=%0d done=%b, want acc=0 done=0", acc, done);
        end
        step();
        step();
        rstn = 1'b1;
        step();
        tests_run++;
        if (acc !== 32'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: acc=%0d done=%b, want acc=0 done=0", acc, done);
        end
    endtask

    task automatic test_run();
        logic [31:0] exp;
        start = 1'b1;
        step();
        tests_run++;
        if (acc !== 32'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_start: acc=%0d done=%b, want acc=0 done=0", acc, done);
        end
        exp = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = exp + 32'(i);
            tests_run++;
            if (acc !== exp || done !== (i == 10)) begin
                tests_failed++;
                $display("FAIL run_step%0d: acc=%0d done=%b, want acc=%0d done=%b",
                         i, acc, done, exp, (i == 10));
            end
        end
    endtask

    task automatic test_hold_start();
        for (int i = 0; i < 20; i++) begin
            step();
            tests_run++;
            if (acc !== 32'd55 || done !== 1'b1) begin
                tests_failed++;
                $display("FAIL hold_start%0d: acc=%0d done=%b, want acc=55 done=1", i, acc, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b0;
        step();
        tests_run++;
        if (acc !== 32'd55 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_start: acc=%0d done=%b, want acc=55 done=0", acc, done);
        end
        step();
        tests_run++;
        if (acc !== 32'd55 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold: acc=%0d done=%b, want acc=55 done=0", acc, done);
        end
        start = 1'b1;
        step();
        tests_run++;
        if (acc !== 32'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart: acc=%0d done=%b, want acc=0 done=0", acc, done);
        end
        for (int i = 1; i <= 9; i++) step();
        tests_run++;
        if (acc !== 32'd45 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rerun9: acc=%0d done=%b, want acc=45 done=0", acc, done);
        end
        step();
        tests_run++;
        if (acc !== 32'd55 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rerun_done: acc=%0d done=%b, want acc=55 done=1", acc, done);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) step();
        tests_run++;
        if (acc !== 32'd15 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_run: acc=%0d done=%b, want acc=15 done=0", acc, done);
        end
        // Assert reset between edges; outputs must clear with no clock.
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if (acc !== 32'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: acc=%0d done=%b, want acc=0 done=0", acc, done);
        end
        start = 1'b0;
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (acc !== 32'd0 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset_idle%0d: acc=%0d done=%b, want acc=0 done=0",
                         i, acc, done);
            end
        end
        start = 1'b1;
        step();
        for (int i = 1; i <= 10; i++) step();
        tests_run++;
        if (acc !== 32'd55 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_run: acc=%0d done=%b, want acc=55 done=1", acc, done);
        end
        start = 1'b0;
    endtask

    task automatic test_n1();
        start1 = 1'b1;
        step();
        tests_run++;
        if (acc1 !== 32'd0 || done1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL n1_start: acc=%0d done=%b, want acc=0 done=0", acc1, done1);
        end
        step();
        tests_run++;
        if (acc1 !== 32'd1 || done1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL n1_done: acc=%0d done=%b, want acc=1 done=1", acc1, done1);
        end
        start1 = 1'b0;
        step();
        tests_run++;
        if (acc1 !== 32'd1 || done1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL n1_release: acc=%0d done=%b, want acc=1 done=0", acc1, done1);
        end
    endtask

    task automatic test_wrap();
        start8 = 1'b1;
        step();
        for (int i = 1; i <= 29; i++) step();
        // 1..29 = 435 -> 179 mod 256
        tests_run++;
        if (acc8 !== 8'd179 || done8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap29: acc=%0d done=%b, want acc=179 done=0", acc8, done8);
        end
        step();
        tests_run++;
        if (acc8 !== 8'd209 || done8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_done: acc=%0d done=%b, want acc=209 done=1", acc8, done8);
        end
        start8 = 1'b0;
    endtask

    task automatic test_max_count();
        startm = 1'b1;
        step();
        for (int i = 1; i <= 65534; i++) step();
        // 1..65534 = 2147385345
        tests_run++;
        if (accm !== 32'd2147385345 || donem !== 1'b0) begin
            tests_failed++;
            $display("FAIL max_pre: acc=%0d done=%b, want acc=2147385345 done=0", accm, donem);
        end
        step();
        tests_run++;
        if (accm !== 32'd2147450880 || donem !== 1'b1) begin
            tests_failed++;
            $display("FAIL max_done: acc=%0d done=%b, want acc=2147450880 done=1", accm, donem);
        end
        startm = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_run();
        test_hold_start();
        test_back_to_back();
        test_reset_mid_run();
        test_n1();
        test_wrap();
        test_max_count();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
